// File: rtl/serial_byte_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : serial_byte_receiver
//  Description : Framed LSB-first serial-to-parallel receiver with a
//                valid/ready output buffer, frame-error and overrun flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_byte_receiver #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  serial_in,
  input  logic                  bit_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  busy,
  output logic                  frame_error,
  output logic                  overrun,
  input  logic                  clear_err
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_ferr, w_ferr_nxt;
  logic                  r_ovr, w_ovr_nxt;
  logic                  w_buf_free;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  // A word being consumed on this edge frees the buffer for a same-edge reload.
  assign w_buf_free = !r_valid || data_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_ferr_nxt  = 1'b0;
    w_ovr_nxt   = r_ovr;

    if (r_valid && data_ready) begin
      w_valid_nxt = 1'b0;
    end
    if (clear_err) begin
      w_ovr_nxt = 1'b0;
    end

    // Overrun set below is evaluated after the clear so a same-edge set wins.
    if (bit_en) begin
      case (r_state)
        S_IDLE: begin
          if (!serial_in) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = '0;
          end
        end
        S_DATA: begin
          w_shift_nxt = {serial_in, r_shift[DATA_WIDTH-1:1]};
          w_cnt_nxt   = r_cnt + 1'b1;
          if (r_cnt == C_LAST_BIT) begin
            w_state_nxt = S_STOP;
            w_cnt_nxt   = '0;
          end
        end
        S_STOP: begin
          w_state_nxt = S_IDLE;
          if (serial_in) begin
            if (w_buf_free) begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
            end else begin
              w_ovr_nxt = 1'b1;
            end
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign busy        = (r_state == S_DATA) || (r_state == S_STOP);
  assign frame_error = r_ferr;
  assign overrun     = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_serial_byte_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_byte_receiver
//  Description : Directed and randomized frames checked against a frame-level
//                reference model of the receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_byte_receiver;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         serial_in;
  logic         bit_en;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         data_ready;
  logic         busy;
  logic         frame_error;
  logic         overrun;
  logic         clear_err;

  serial_byte_receiver #(.DATA_WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .serial_in   (serial_in),
    .bit_en      (bit_en),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .busy        (busy),
    .frame_error (frame_error),
    .overrun     (overrun),
    .clear_err   (clear_err)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: position within frame (-1 idle, 0..W-1 data, W stop).
  int           m_pos;
  logic [W-1:0] m_word;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ferr;
  logic         m_ovr;

  bit   rnd_mode;
  logic rdy_base;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = -1; m_word = '0; m_data = '0;
    m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_step();
    logic free;
    free   = !m_valid || data_ready;
    m_ferr = 1'b0;
    if (m_valid && data_ready) m_valid = 1'b0;
    if (clear_err) m_ovr = 1'b0;
    if (bit_en) begin
      if (m_pos < 0) begin
        if (!serial_in) begin
          m_pos  = 0;
          m_word = '0;
        end
      end else if (m_pos < W) begin
        m_word[m_pos] = serial_in;
        m_pos++;
      end else begin
        m_pos = -1;
        if (serial_in) begin
          if (free) begin
            m_data  = m_word;
            m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end else begin
          m_ferr = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    check_val("data_out", 32'(data_out), 32'(m_data));
    check_val("data_valid", 32'(data_valid), 32'(m_valid));
    check_val("busy", 32'(busy), 32'(m_pos >= 0));
    check_val("frame_error", 32'(frame_error), 32'(m_ferr));
    check_val("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic cycle(input logic sin, input logic be, input logic rdy, input logic clr);
    serial_in  = sin;
    bit_en     = be;
    data_ready = rdy;
    clear_err  = clr;
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  function automatic logic pick_rdy();
    return rnd_mode ? ($urandom % 3 == 0) : rdy_base;
  endfunction

  function automatic logic pick_clr();
    return rnd_mode && ($urandom % 16 == 0);
  endfunction

  // Unstrobed gap cycles carry random line values that must be ignored.
  task automatic send_frame(input logic [W-1:0] d, input logic stop_b, input int gap,
                            input int rdy_at_stop);
    logic [W+1:0] bits;
    logic         r;
    bits = {stop_b, d, 1'b0};
    for (int i = 0; i < W + 2; i++) begin
      r = pick_rdy();
      if (i == W + 1 && rdy_at_stop >= 0) r = rdy_at_stop[0];
      cycle(bits[i], 1'b1, r, pick_clr());
      if (i != W + 1)
        for (int g = 0; g < gap; g++) cycle(1'($urandom % 2), 1'b0, pick_rdy(), 1'b0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; serial_in = 1'b1; bit_en = 1'b0; data_ready = 1'b0; clear_err = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    rnd_mode = 1'b0;
    rdy_base = 1'b0;
    #2;
    do_reset();

    // Single frame 0xA5, consumer not ready
    send_frame(8'hA5, 1'b1, 0, -1);
    check_val("a5_data", 32'(data_out), 32'h000000A5);
    check_val("a5_valid", 32'(data_valid), 32'd1);

    // Data holds while not accepted, then a one-cycle accept
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("hold_data", 32'(data_out), 32'h000000A5);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check_val("accept_valid", 32'(data_valid), 32'd0);

    // Overrun then clear
    send_frame(8'h3C, 1'b1, 0, -1);
    send_frame(8'hFF, 1'b1, 0, -1);
    check_val("ovr_data", 32'(data_out), 32'h0000003C);
    check_val("ovr_flag", 32'(overrun), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check_val("ovr_clear", 32'(overrun), 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);

    // Accept and reload on the same edge
    send_frame(8'h5A, 1'b1, 0, -1);
    send_frame(8'h81, 1'b1, 0, 1);
    check_val("coll_valid", 32'(data_valid), 32'd1);
    check_val("coll_data", 32'(data_out), 32'h00000081);
    check_val("coll_ovr", 32'(overrun), 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);

    // Frame error then a good frame
    send_frame(8'h55, 1'b0, 0, -1);
    check_val("ferr_pulse", 32'(frame_error), 32'd1);
    check_val("ferr_valid", 32'(data_valid), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("ferr_one_cycle", 32'(frame_error), 32'd0);
    send_frame(8'h12, 1'b1, 0, -1);
    check_val("after_ferr_data", 32'(data_out), 32'h00000012);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);

    // Sparse strobe (every 3rd cycle)
    send_frame(8'hC3, 1'b1, 2, -1);
    check_val("sparse_data", 32'(data_out), 32'h000000C3);
    check_val("sparse_valid", 32'(data_valid), 32'd1);

    // Reset after 4 data bits, then a clean frame
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    check_val("rst_data", 32'(data_out), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    send_frame(8'h0F, 1'b1, 0, -1);
    check_val("post_rst_data", 32'(data_out), 32'h0000000F);

    // Randomized traffic
    rnd_mode = 1'b1;
    for (int f = 0; f < 60; f++) begin
      send_frame(8'($urandom), 1'($urandom % 8 != 0), int'($urandom % 3), -1);
      for (int k = 0; k < int'($urandom % 3); k++)
        cycle(1'b1, 1'($urandom % 2), pick_rdy(), pick_clr());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
